// File: rtl/memory_stage.sv
// EX/MEM pipeline register and data-memory access stage.
// Ports: ex_* execute bundle in, dm_* req/ack memory bus, wb_* + exception pulses out, stall upstream.
module memory_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [5:0]  ex_opc,
    input  logic        ex_res_sel,
    input  logic [31:0] ex_alu_res,
    input  logic [31:0] ex_shift_res,
    input  logic [31:0] ex_dm_in,
    input  logic [31:0] ex_ea,
    input  logic        ex_ovf,
    input  logic [4:0]  ex_rd,
    input  logic        ex_wen,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        wb_valid,
    output logic        wb_wen,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        ovf_exc,
    output logic        adr_exc,
    output logic        bus_err
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    // access size encoding
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // decode of the incoming opcode
    logic            ex_ld, ex_st, ex_sgn, ex_mis;
    logic [1:0]      ex_sz;

    // bundle captured for the memory access
    logic [31:0]     ea_q, din_q;
    logic [4:0]      rd_q;
    logic            wen_q, st_q, sgn_q;
    logic [1:0]      sz_q;

    // next values of the registered writeback bundle
    logic            wb_valid_d, wb_wen_d, ovf_d, adr_d, berr_d;
    logic [4:0]      wb_rd_d;
    logic [31:0]     wb_data_d;

    logic [1:0]      lane;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_data;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic            in_access, capture, timed_out;

    always_comb begin
        ex_ld  = 1'b0;
        ex_st  = 1'b0;
        ex_sgn = 1'b0;
        ex_sz  = SZ_W;
        case (ex_opc)
            6'h20: begin ex_ld = 1'b1; ex_sz = SZ_B; ex_sgn = 1'b1; end
            6'h21: begin ex_ld = 1'b1; ex_sz = SZ_H; ex_sgn = 1'b1; end
            6'h23: begin ex_ld = 1'b1; ex_sz = SZ_W; end
            6'h24: begin ex_ld = 1'b1; ex_sz = SZ_B; end
            6'h25: begin ex_ld = 1'b1; ex_sz = SZ_H; end
            6'h28: begin ex_st = 1'b1; ex_sz = SZ_B; end
            6'h29: begin ex_st = 1'b1; ex_sz = SZ_H; end
            6'h2B: begin ex_st = 1'b1; ex_sz = SZ_W; end
            default: ;
        endcase
        ex_mis = (ex_ld | ex_st) &
                 (((ex_sz == SZ_H) & ex_ea[0]) |
                  ((ex_sz == SZ_W) & (ex_ea[1:0] != 2'b00)));
    end

    assign in_access = (state_q == ACCESS);
    assign capture   = (state_q == IDLE) & ex_valid &
                       (ex_ld | ex_st) & ~ex_mis;
    // last counted ACCESS cycle without ack ends the access
    assign timed_out = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));

    // lane selection for loads (little-endian)
    assign lane    = ea_q[1:0];
    assign ld_byte = dm_rdata[8*lane +: 8];
    assign ld_half = dm_rdata[16*ea_q[1] +: 16];

    always_comb begin
        ld_data = dm_rdata;
        be      = 4'b1111;
        wdata   = din_q;
        case (sz_q)
            SZ_B: begin
                ld_data = {{24{sgn_q & ld_byte[7]}}, ld_byte};
                be      = 4'b0001 << lane;
                wdata   = {4{din_q[7:0]}};
            end
            SZ_H: begin
                ld_data = {{16{sgn_q & ld_half[15]}}, ld_half};
                be      = ea_q[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{din_q[15:0]}};
            end
            default: ;
        endcase
    end

    // bus outputs are only live while an access is outstanding
    assign stall    = in_access;
    assign dm_req   = in_access;
    assign dm_we    = in_access & st_q;
    assign dm_addr  = in_access ? {ea_q[31:2], 2'b00} : 32'd0;
    assign dm_be    = in_access ? be : 4'd0;
    assign dm_wdata = in_access ? wdata : 32'd0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wb_valid_d = 1'b0;
        wb_wen_d   = 1'b0;
        wb_rd_d    = 5'd0;
        wb_data_d  = 32'd0;
        ovf_d      = 1'b0;
        adr_d      = 1'b0;
        berr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_ld | ex_st) begin
                        if (ex_mis) begin
                            wb_valid_d = 1'b1;
                            wb_rd_d    = ex_rd;
                            adr_d      = 1'b1;
                        end else begin
                            state_d = ACCESS;
                            cnt_d   = '0;
                        end
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = ex_rd;
                        wb_data_d  = ex_res_sel ? ex_shift_res : ex_alu_res;
                        if (ex_ovf & ex_wen) begin
                            ovf_d = 1'b1;
                        end else begin
                            wb_wen_d = ex_wen;
                        end
                    end
                end
            end
            ACCESS: begin
                if (dm_ack) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    if (!st_q) begin
                        wb_wen_d  = wen_q;
                        wb_data_d = ld_data;
                    end
                end else if (timed_out) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    berr_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wb_valid <= 1'b0;
            wb_wen   <= 1'b0;
            wb_rd    <= 5'd0;
            wb_data  <= 32'd0;
            ovf_exc  <= 1'b0;
            adr_exc  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wb_valid <= wb_valid_d;
            wb_wen   <= wb_wen_d;
            wb_rd    <= wb_rd_d;
            wb_data  <= wb_data_d;
            ovf_exc  <= ovf_d;
            adr_exc  <= adr_d;
            bus_err  <= berr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ea_q  <= 32'd0;
            din_q <= 32'd0;
            rd_q  <= 5'd0;
            wen_q <= 1'b0;
            st_q  <= 1'b0;
            sgn_q <= 1'b0;
            sz_q  <= SZ_W;
        end else if (capture) begin
            ea_q  <= ex_ea;
            din_q <= ex_dm_in;
            rd_q  <= ex_rd;
            wen_q <= ex_wen;
            st_q  <= ex_st;
            sgn_q <= ex_sgn;
            sz_q  <= ex_sz;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage.
// Stimulus pushes expected writeback bundles; a negedge monitor pops and compares.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [5:0]  ex_opc;
    logic        ex_res_sel;
    logic [31:0] ex_alu_res, ex_shift_res, ex_dm_in, ex_ea;
    logic        ex_ovf;
    logic [4:0]  ex_rd;
    logic        ex_wen;
    logic        stall, dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic        wb_valid, wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ovf_exc, adr_exc, bus_err;

    typedef struct packed {
        logic        valid;
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ovf;
        logic        adr;
        logic        berr;
    } wb_t;

    wb_t sb[$];
    wb_t act_m, exp_m;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n;

    memory_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_opc(ex_opc), .ex_res_sel(ex_res_sel),
        .ex_alu_res(ex_alu_res), .ex_shift_res(ex_shift_res),
        .ex_dm_in(ex_dm_in), .ex_ea(ex_ea), .ex_ovf(ex_ovf),
        .ex_rd(ex_rd), .ex_wen(ex_wen),
        .stall(stall), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
        .wb_data(wb_data), .ovf_exc(ovf_exc), .adr_exc(adr_exc),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic wen, input logic [4:0] rd,
                        input logic [31:0] data, input logic ovf,
                        input logic adr, input logic berr);
        wb_t e;
        e = '{valid: 1'b1, wen: wen, rd: rd, data: data,
              ovf: ovf, adr: adr, berr: berr};
        sb.push_back(e);
    endtask

    // Presents one bundle for one clock edge; returns at posedge+1.
    task automatic issue(input logic [5:0] opc, input logic sel,
                         input logic [31:0] alu, input logic [31:0] shf,
                         input logic [31:0] din, input logic [31:0] ea,
                         input logic ovf, input logic [4:0] rd,
                         input logic wen);
        ex_opc = opc; ex_res_sel = sel; ex_alu_res = alu;
        ex_shift_res = shf; ex_dm_in = din; ex_ea = ea;
        ex_ovf = ovf; ex_rd = rd; ex_wen = wen; ex_valid = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    // Serves an outstanding access; acks in ACCESS cycle ack_at (0 = never).
    task automatic serve(input int ack_at, input logic [31:0] rdata,
                         output int cycles);
        cycles = 0;
        dm_rdata = rdata;
        while (dm_req === 1'b1 && cycles < 64) begin
            cycles++;
            chk("stall_in_access", {31'd0, stall}, 32'd1);
            dm_ack = (cycles == ack_at);
            @(posedge clk); #1;
        end
        dm_ack = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && (wb_valid | ovf_exc | adr_exc | bus_err)) begin
            act_m = '{valid: wb_valid, wen: wb_wen, rd: wb_rd,
                      data: wb_data, ovf: ovf_exc, adr: adr_exc,
                      berr: bus_err};
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got %h expected none", act_m);
            end else begin
                exp_m = sb.pop_front();
                if (act_m !== exp_m) begin
                    n_fail++;
                    $display("FAIL wb_bundle: got %h expected %h",
                             act_m, exp_m);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_opc = 6'd0; ex_res_sel = 1'b0;
        ex_alu_res = 0; ex_shift_res = 0; ex_dm_in = 0; ex_ea = 0;
        ex_ovf = 1'b0; ex_rd = 5'd0; ex_wen = 1'b0;
        dm_rdata = 0; dm_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_dm_addr", dm_addr, 32'd0);
        chk("rst_dm_be", {28'd0, dm_be}, 32'd0);
        chk("rst_exc", {29'd0, ovf_exc, adr_exc, bus_err}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // non-memory ops, ALU then shift source
        push(1'b1, 5'd3, 32'h5, 1'b0, 1'b0, 1'b0);
        issue(6'h00, 1'b0, 32'h5, 32'h77, 0, 0, 1'b0, 5'd3, 1'b1);
        chk("add_latency", {31'd0, wb_valid}, 32'd1);
        @(posedge clk); #1;
        push(1'b1, 5'd3, 32'hF0, 1'b0, 1'b0, 1'b0);
        issue(6'h00, 1'b1, 32'h99, 32'hF0, 0, 0, 1'b0, 5'd3, 1'b1);
        chk("shift_latency", {31'd0, wb_valid}, 32'd1);
        @(posedge clk); #1;

        // back-to-back non-memory ops
        push(1'b1, 5'd4, 32'h11, 1'b0, 1'b0, 1'b0);
        push(1'b1, 5'd5, 32'h22, 1'b0, 1'b0, 1'b0);
        issue(6'h00, 1'b0, 32'h11, 0, 0, 0, 1'b0, 5'd4, 1'b1);
        chk("b2b_stall", {31'd0, stall}, 32'd0);
        issue(6'h00, 1'b0, 32'h22, 0, 0, 0, 1'b0, 5'd5, 1'b1);
        chk("b2b_second_valid", {31'd0, wb_valid}, 32'd1);
        @(posedge clk); #1;

        // LB, lane 3, sign-extended, ack in 3rd ACCESS cycle
        push(1'b1, 5'd7, 32'hFFFF_FF80, 1'b0, 1'b0, 1'b0);
        issue(6'h20, 1'b0, 0, 0, 0, 32'h1003, 1'b0, 5'd7, 1'b1);
        chk("lb_be", {28'd0, dm_be}, 32'b1000);
        chk("lb_addr", dm_addr, 32'h1000);
        chk("lb_we", {31'd0, dm_we}, 32'd0);
        serve(3, 32'h80AA_BBCC, n);
        chk("lb_cycles", n, 32'd3);
        @(posedge clk); #1;

        // LBU same access
        push(1'b1, 5'd8, 32'h0000_0080, 1'b0, 1'b0, 1'b0);
        issue(6'h24, 1'b0, 0, 0, 0, 32'h1003, 1'b0, 5'd8, 1'b1);
        serve(3, 32'h80AA_BBCC, n);
        chk("lbu_cycles", n, 32'd3);

        // LH / LHU upper half
        push(1'b1, 5'd9, 32'hFFFF_8001, 1'b0, 1'b0, 1'b0);
        issue(6'h21, 1'b0, 0, 0, 0, 32'h0002, 1'b0, 5'd9, 1'b1);
        chk("lh_be", {28'd0, dm_be}, 32'b1100);
        serve(1, 32'h8001_0000, n);
        push(1'b1, 5'd10, 32'h0000_8001, 1'b0, 1'b0, 1'b0);
        issue(6'h25, 1'b0, 0, 0, 0, 32'h0002, 1'b0, 5'd10, 1'b1);
        serve(2, 32'h8001_0000, n);

        // SH with immediate ack
        push(1'b0, 5'd11, 32'd0, 1'b0, 1'b0, 1'b0);
        issue(6'h29, 1'b0, 0, 0, 32'h1234_ABCD, 32'h2002, 1'b0, 5'd11, 1'b1);
        chk("sh_we", {31'd0, dm_we}, 32'd1);
        chk("sh_be", {28'd0, dm_be}, 32'b1100);
        chk("sh_wdata", dm_wdata, 32'hABCD_ABCD);
        chk("sh_addr", dm_addr, 32'h2000);
        serve(1, 0, n);
        chk("sh_cycles", n, 32'd1);

        // SB lane 1
        push(1'b0, 5'd12, 32'd0, 1'b0, 1'b0, 1'b0);
        issue(6'h28, 1'b0, 0, 0, 32'hCAFE_0077, 32'h0005, 1'b0, 5'd12, 1'b1);
        chk("sb_be", {28'd0, dm_be}, 32'b0010);
        chk("sb_wdata", dm_wdata, 32'h7777_7777);
        serve(2, 0, n);

        // misaligned LW, then overflowing ADD
        push(1'b0, 5'd13, 32'd0, 1'b0, 1'b1, 1'b0);
        issue(6'h23, 1'b0, 0, 0, 0, 32'h0001, 1'b0, 5'd13, 1'b1);
        chk("mis_no_req", {31'd0, dm_req}, 32'd0);
        chk("mis_adr_exc", {31'd0, adr_exc}, 32'd1);
        push(1'b0, 5'd14, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
        issue(6'h00, 1'b0, 32'h7FFF_FFFF, 0, 0, 0, 1'b1, 5'd14, 1'b1);
        chk("ovf_exc", {31'd0, ovf_exc}, 32'd1);
        @(posedge clk); #1;

        // LW timeout, then ack on the last allowed cycle
        push(1'b0, 5'd15, 32'd0, 1'b0, 1'b0, 1'b1);
        issue(6'h23, 1'b0, 0, 0, 0, 32'h0040, 1'b0, 5'd15, 1'b1);
        serve(0, 32'h1111_1111, n);
        chk("timeout_cycles", n, 32'd16);
        chk("timeout_bus_err", {31'd0, bus_err}, 32'd1);
        chk("timeout_idle", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        push(1'b1, 5'd16, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        issue(6'h23, 1'b0, 0, 0, 0, 32'h0040, 1'b0, 5'd16, 1'b1);
        serve(16, 32'hDEAD_BEEF, n);
        chk("ack16_cycles", n, 32'd16);
        chk("ack16_no_bus_err", {31'd0, bus_err}, 32'd0);
        @(posedge clk); #1;

        // reset in the middle of an access
        issue(6'h23, 1'b0, 0, 0, 0, 32'h0080, 1'b0, 5'd17, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, dm_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_wb", {31'd0, wb_valid}, 32'd0);
        chk("mid_rst_be", {28'd0, dm_be}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        dm_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_ack_ignored", {31'd0, wb_valid}, 32'd0);
        dm_ack = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
